// File: rtl/adv7513_i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single ADV7513 i2c_master command port.
// Define ADV7513_I2C_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES in S_WAIT.
module adv7513_i2c_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit ID0_PRIORITY   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rq_req,
  input  logic [1:0] rq_rd,
  input  logic [6:0] rq_chip_addr0,
  input  logic [6:0] rq_chip_addr1,
  input  logic [7:0] rq_reg_addr0,
  input  logic [7:0] rq_reg_addr1,
  input  logic [7:0] rq_wdata0,
  input  logic [7:0] rq_wdata1,
  output logic [1:0] rq_grant,
  output logic [1:0] rq_done,
  output logic       rq_err,
  output logic [7:0] rq_rdata,
  output logic [6:0] m_chip_addr,
  output logic [7:0] m_reg_addr,
  output logic [7:0] m_data_in,
  output logic       m_write_en,
  output logic       m_read_en,
  input  logic       m_done,
  input  logic       m_busy,
  input  logic [2:0] m_status,
  input  logic [7:0] m_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  (* fsm_safe_state = "reset_state" *) state_t state_reg;
  logic last_reg;
  logic owner_reg;
  logic op_rd_reg;
  logic win;
  logic strobe;

`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;
`endif

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = rq_req[1];
    if (rq_req == 2'b11) win = ~last_reg;
  end

  assign strobe = m_write_en | m_read_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      last_reg    <= ID0_PRIORITY ? 1'b1 : 1'b0;
      owner_reg   <= 1'b0;
      op_rd_reg   <= 1'b0;
      rq_grant    <= 2'b00;
      rq_done     <= 2'b00;
      rq_err      <= 1'b0;
      rq_rdata    <= 8'h00;
      m_chip_addr <= 7'h00;
      m_reg_addr  <= 8'h00;
      m_data_in   <= 8'h00;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
      tmo_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if ((|rq_req) && !m_busy) begin
            owner_reg   <= win;
            op_rd_reg   <= win ? rq_rd[1] : rq_rd[0];
            m_chip_addr <= win ? rq_chip_addr1 : rq_chip_addr0;
            m_reg_addr  <= win ? rq_reg_addr1 : rq_reg_addr0;
            m_data_in   <= win ? rq_wdata1 : rq_wdata0;
            rq_grant    <= win ? 2'b10 : 2'b01;
            state_reg   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_read_en  <= op_rd_reg;
          m_write_en <= ~op_rd_reg;
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          state_reg  <= S_WAIT;
        end
        S_WAIT: begin
          m_read_en  <= 1'b0;
          m_write_en <= 1'b0;
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
`endif
          // A done that coincides with the strobe belongs to no command of ours.
          if (m_done && !strobe) begin
            if (op_rd_reg) rq_rdata <= m_data_out;
            rq_err    <= (m_status != 3'b000);
            rq_done   <= rq_grant;
            state_reg <= S_DONE;
          end
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
          else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            rq_err    <= 1'b1;
            rq_done   <= rq_grant;
            state_reg <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          rq_done   <= 2'b00;
          rq_grant  <= 2'b00;
          last_reg  <= owner_reg;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adv7513_i2c_arbiter.sv
// Scoreboard bench for adv7513_i2c_arbiter: directed transactions against a small i2c_master model.
module tb_adv7513_i2c_arbiter;

`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1000000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rq_req, rq_rd;
  logic [6:0] rq_chip_addr0, rq_chip_addr1;
  logic [7:0] rq_reg_addr0, rq_reg_addr1, rq_wdata0, rq_wdata1;
  logic [1:0] rq_grant, rq_done;
  logic       rq_err;
  logic [7:0] rq_rdata;
  logic [6:0] m_chip_addr;
  logic [7:0] m_reg_addr, m_data_in;
  logic       m_write_en, m_read_en;
  logic       m_done, m_busy;
  logic [2:0] m_status;
  logic [7:0] m_data_out;

  adv7513_i2c_arbiter #(.TIMEOUT_CYCLES(TMO), .ID0_PRIORITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rq_req(rq_req), .rq_rd(rq_rd),
    .rq_chip_addr0(rq_chip_addr0), .rq_chip_addr1(rq_chip_addr1),
    .rq_reg_addr0(rq_reg_addr0), .rq_reg_addr1(rq_reg_addr1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
    .rq_grant(rq_grant), .rq_done(rq_done), .rq_err(rq_err), .rq_rdata(rq_rdata),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_done(m_done), .m_busy(m_busy), .m_status(m_status), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] owner;
    logic       rd;
    logic [6:0] chip;
    logic [7:0] reg_a;
    logic [7:0] wd;
    logic       err;
    logic [7:0] rdata;
    bit         tmo;
  } txn_t;

  txn_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // i2c_master model knobs
  int         mdl_delay = 3;
  int         mdl_tail  = 0;
  logic [2:0] mdl_status = 3'b000;
  logic [7:0] mdl_data = 8'h00;
  bit         mdl_hang = 0;
  bit         mdl_early = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event/none expected none/event (cycle %0d)", name, cyc);
  endtask

  task automatic push(input logic [1:0] own, input logic rd, input logic [6:0] chip,
                      input logic [7:0] ra, input logic [7:0] wd, input logic err,
                      input logic [7:0] rdata, input bit tmo);
    txn_t e;
    e.owner = own; e.rd = rd; e.chip = chip; e.reg_a = ra; e.wd = wd;
    e.err = err; e.rdata = rdata; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic rd, input logic [6:0] chip,
                         input logic [7:0] ra, input logic [7:0] wd);
    if (idx == 0) begin
      rq_rd[0] = rd; rq_chip_addr0 = chip; rq_reg_addr0 = ra; rq_wdata0 = wd; rq_req[0] = 1'b1;
    end else begin
      rq_rd[1] = rd; rq_chip_addr1 = chip; rq_reg_addr1 = ra; rq_wdata1 = wd; rq_req[1] = 1'b1;
    end
  endtask

  task automatic wait_done(input int idx, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rq_done[idx]) seen = 1;
    end
    if (!seen) fail_now($sformatf("done_timeout_req%0d", idx));
  endtask

  task automatic wait_strobe(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (m_write_en || m_read_en) seen = 1;
    end
    if (!seen) fail_now("strobe_timeout");
  endtask

  // i2c_master model: busy from strobe until done (+ optional tail), done after mdl_delay cycles.
  initial begin
    int cnt = 0;
    int tail = 0;
    m_done = 1'b0; m_busy = 1'b0; m_status = 3'b000; m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (reset) begin
        m_busy = 1'b0; cnt = 0; tail = 0;
      end else if (m_write_en || m_read_en) begin
        m_busy = 1'b1;
        cnt = mdl_delay;
        if (mdl_early) begin
          m_done = 1'b1; m_status = 3'b000; m_data_out = 8'hEE;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (mdl_hang) m_busy = 1'b0;
          else begin
            m_done = 1'b1; m_status = mdl_status; m_data_out = mdl_data;
            tail = mdl_tail;
            if (tail == 0) m_busy = 1'b0;
          end
        end
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) m_busy = 1'b0;
      end
    end
  end

  // Monitor: compares strobes and completions against the scoreboard front.
  initial begin
    logic [1:0] prev_grant = 2'b00;
    logic       prev_strobe = 1'b0;
    int         rise_cyc = 0;
    int         strobe_cyc = 0;
    txn_t       e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        prev_grant = 2'b00; prev_strobe = 1'b0;
        continue;
      end
      if (rq_grant != 2'b00 && prev_grant == 2'b00) rise_cyc = cyc;
      if (m_write_en || m_read_en) begin
        if (sb.size() == 0) fail_now("unexpected_strobe");
        else begin
          e = sb[0];
          check("strobe_op", {m_read_en, m_write_en}, e.rd ? 2'b10 : 2'b01);
          check("cmd_fields", {m_chip_addr, m_reg_addr, m_data_in}, {e.chip, e.reg_a, e.wd});
          check("grant_owner", rq_grant, e.owner);
          check("strobe_latency", cyc - rise_cyc, 1);
          check("strobe_while_busy", m_busy, 0);
          check("strobe_width", prev_strobe, 0);
          strobe_cyc = cyc;
        end
      end
      if (rq_done != 2'b00) begin
        if (sb.size() == 0) fail_now("unexpected_done");
        else begin
          e = sb.pop_front();
          check("done_owner", rq_done, e.owner);
          check("done_err", rq_err, e.err);
          check("done_rdata", rq_rdata, e.rdata);
          check("cmd_stable", {m_chip_addr, m_reg_addr, m_data_in}, {e.chip, e.reg_a, e.wd});
          if (e.tmo) check("timeout_latency", cyc - strobe_cyc, TMO);
          else check("done_latency_mdone", m_done, 1);
        end
      end
      prev_grant  = rq_grant;
      prev_strobe = m_write_en | m_read_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, nd;
    reset = 1'b1;
    rq_req = 2'b00; rq_rd = 2'b00;
    rq_chip_addr0 = 7'h00; rq_chip_addr1 = 7'h00;
    rq_reg_addr0 = 8'h00; rq_reg_addr1 = 8'h00;
    rq_wdata0 = 8'h00; rq_wdata1 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rq_grant, rq_done, rq_err, rq_rdata, m_chip_addr, m_reg_addr,
                            m_data_in, m_write_en, m_read_en}, 0);
    reset = 1'b0;

    // Single write: grant after 1 cycle, strobe 2 cycles after request.
    push(2'b01, 1'b0, 7'h39, 8'h41, 8'h10, 1'b0, 8'h00, 0);
    @(negedge clk);
    set_req(0, 1'b0, 7'h39, 8'h41, 8'h10);
    @(posedge clk); #1;
    check("accept_grant", rq_grant, 2'b01);
    @(posedge clk); #1;
    check("write_strobe_2cyc", m_write_en, 1);
    wait_done(0, 50);
    rq_req[0] = 1'b0;
    $display("txn single write done");

    // Read by requester 1 returns 0xA5, which then survives a write.
    mdl_data = 8'hA5;
    push(2'b10, 1'b1, 7'h39, 8'h42, 8'h00, 1'b0, 8'hA5, 0);
    set_req(1, 1'b1, 7'h39, 8'h42, 8'h00);
    wait_done(1, 50);
    rq_req[1] = 1'b0;
    $display("txn read A5 done");
    mdl_data = 8'h3C;
    push(2'b01, 1'b0, 7'h39, 8'h43, 8'h55, 1'b0, 8'hA5, 0);
    set_req(0, 1'b0, 7'h39, 8'h43, 8'h55);
    wait_done(0, 50);
    rq_req[0] = 1'b0;
    $display("txn write after read done");

    // Nonzero status flags an error.
    mdl_status = 3'b010;
    push(2'b10, 1'b0, 7'h39, 8'h45, 8'h77, 1'b1, 8'hA5, 0);
    set_req(1, 1'b0, 7'h39, 8'h45, 8'h77);
    wait_done(1, 50);
    rq_req[1] = 1'b0;
    mdl_status = 3'b000;
    $display("txn status error done");

    // Owner drops request and scrambles its inputs mid-transaction.
    mdl_delay = 6;
    push(2'b01, 1'b0, 7'h39, 8'h46, 8'h21, 1'b0, 8'hA5, 0);
    set_req(0, 1'b0, 7'h39, 8'h46, 8'h21);
    wait_strobe(20);
    @(negedge clk);
    rq_req[0] = 1'b0; rq_reg_addr0 = 8'hFF; rq_wdata0 = 8'h00; rq_chip_addr0 = 7'h11;
    wait_done(0, 50);
    $display("txn drop mid-wait done");

    // Reset in S_WAIT: outputs cleared and no completion follows.
    mdl_hang = 1; mdl_delay = 20;
    push(2'b01, 1'b0, 7'h39, 8'h47, 8'h33, 1'b0, 8'h00, 0);
    set_req(0, 1'b0, 7'h39, 8'h47, 8'h33);
    wait_strobe(20);
    repeat (2) @(negedge clk);
    check("grant_before_reset", rq_grant, 2'b01);
    reset = 1'b1; rq_req = 2'b00;
    sb.delete();
    @(negedge clk);
    check("reset_mid_outputs", {rq_grant, rq_done, rq_err, rq_rdata, m_chip_addr, m_reg_addr,
                                m_data_in, m_write_en, m_read_en}, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    $display("txn reset mid-wait done");

`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
    mdl_delay = 30;
    push(2'b01, 1'b0, 7'h39, 8'h48, 8'h44, 1'b1, 8'h00, 1);
    set_req(0, 1'b0, 7'h39, 8'h48, 8'h44);
    wait_done(0, 100);
    rq_req[0] = 1'b0;
    repeat (20) @(negedge clk);
    $display("txn timeout done");
`endif
    mdl_hang = 0;

    // m_done coinciding with the strobe is ignored.
    mdl_early = 1; mdl_delay = 4; mdl_data = 8'h5A;
    push(2'b10, 1'b1, 7'h39, 8'h44, 8'h00, 1'b0, 8'h5A, 0);
    set_req(1, 1'b1, 7'h39, 8'h44, 8'h00);
    wait_done(1, 50);
    rq_req[1] = 1'b0;
    mdl_early = 0;
    $display("txn early done ignored");

    // Both requesting after reset: grants alternate 0,1,0,1 with master busy tail.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mdl_tail = 3; mdl_delay = 3;
    push(2'b01, 1'b0, 7'h39, 8'h10, 8'h01, 1'b0, 8'h00, 0);
    push(2'b10, 1'b0, 7'h38, 8'h20, 8'h02, 1'b0, 8'h00, 0);
    push(2'b01, 1'b0, 7'h39, 8'h10, 8'h01, 1'b0, 8'h00, 0);
    push(2'b10, 1'b0, 7'h38, 8'h20, 8'h02, 1'b0, 8'h00, 0);
    set_req(0, 1'b0, 7'h39, 8'h10, 8'h01);
    set_req(1, 1'b0, 7'h38, 8'h20, 8'h02);
    c0 = 0; c1 = 0; nd = 0;
    for (int i = 0; i < 400 && nd < 4; i++) begin
      @(negedge clk);
      if (rq_done[0]) begin c0++; nd++; if (c0 == 2) rq_req[0] = 1'b0; end
      if (rq_done[1]) begin c1++; nd++; if (c1 == 2) rq_req[1] = 1'b0; end
    end
    check("rr_completions", nd, 4);
    rq_req = 2'b00;
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("txn round robin x4 done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adv7513_i2c_arbiter.md
ADV7513_I2C_ARBITER -- requirements
Module: adv7513_i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, max cycles allowed in S_WAIT before abort.
REQ-002 Parameter ID0_PRIORITY, default 1; 1 gives requester 0 the first grant after reset, 0 gives requester 1.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rq_req[1:0]  input  2  per-requester transaction request, level, held until matching rq_done.
REQ-006 rq_rd[1:0]  input  2  per-requester op: 1 read, 0 write.
REQ-007 rq_chip_addr0/1  input  7 each  target I2C chip address.
REQ-008 rq_reg_addr0/1  input  8 each  register address.
REQ-009 rq_wdata0/1  input  8 each  write data.
REQ-010 rq_grant[1:0]  output  2  one-hot, requester owning the bus; high S_ISSUE through S_DONE.
REQ-011 rq_done[1:0]  output  2  one-cycle completion pulse to the owner.
REQ-012 rq_err  output  1  valid with rq_done; 1 = nonzero i2c status or timeout.
REQ-013 rq_rdata  output  8  read data, valid with rq_done, held until the next completion.
REQ-014 m_chip_addr 7, m_reg_addr 8, m_data_in 8, m_write_en 1, m_read_en 1  outputs  command port to i2c_master.
REQ-015 m_done 1, m_busy 1, m_status 3, m_data_out 8  inputs  from i2c_master.

Function
REQ-016 FSM states are S_IDLE, S_ISSUE, S_WAIT, S_DONE; encoding uses the safe attribute.
REQ-017 S_IDLE: when any rq_req is high and m_busy is low, select the winner, latch its addr, data and op into m_* registers, set rq_grant, and go to S_ISSUE.
REQ-018 Arbitration is round-robin: with both requests high, the winner is the requester not served last; with one request, that requester wins.
REQ-019 S_ISSUE: assert exactly one of m_write_en/m_read_en for exactly one cycle, then go to S_WAIT.
REQ-020 S_WAIT: on m_done, capture m_data_out into rq_rdata on reads, set rq_err = (m_status != 0), and go to S_DONE.
REQ-021 S_DONE: pulse rq_done[owner] for one cycle, update the last-served pointer, clear rq_grant, and return to S_IDLE.
REQ-022 Latency from request acceptance to command strobe is 2 cycles; from m_done to rq_done it is 1 cycle.
REQ-023 m_* command fields stay stable from S_ISSUE until S_DONE exits, regardless of requester input changes.
REQ-024 If the owner drops rq_req mid-transaction, the transaction still completes and rq_done still pulses.
REQ-025 A request arriving while the bus is owned waits; it cannot preempt the owner.
REQ-026 If m_done arrives in the same cycle as the strobe in S_ISSUE, it is ignored; only m_done seen in S_WAIT counts.
REQ-027 The minimum gap between consecutive grants is 1 S_IDLE cycle.

Reset
REQ-028 Reset forces S_IDLE; m_write_en, m_read_en, rq_grant, rq_done, rq_err = 0; rq_rdata and m_* fields = 0.
REQ-029 After reset, the last-served pointer is set so the first tie goes to the requester selected by ID0_PRIORITY.
REQ-030 Reset mid-transaction aborts with no rq_done pulse; the i2c_master is reset by the same signal.

Configuration
REQ-031 Macro ADV7513_I2C_ARB_TIMEOUT_EN defined: a counter runs in S_WAIT; if it reaches TIMEOUT_CYCLES without m_done, go to S_DONE with rq_err = 1 and rq_rdata unchanged; the counter clears on entry to S_WAIT.
REQ-032 Macro ADV7513_I2C_ARB_TIMEOUT_EN undefined: there is no counter and S_WAIT waits indefinitely for m_done.

Verification
REQ-033 Single write: req0 (chip 0x39, reg 0x41, data 0x10) -> m_write_en pulses once 2 cycles later with those fields; model m_done -> rq_done[0] next cycle, rq_err = 0.
REQ-034 Simultaneous: req0 and req1 high after reset -> grants 0,1,0,1 alternate over 4 back-to-back transactions, and no strobe is issued while m_busy is high.
REQ-035 Read: req1 read reg 0x42, model returns 0xA5 with status 0 -> rq_rdata = 0xA5 with rq_done[1], and it holds through a later write.
REQ-036 Error: model m_status = 3'b010 on m_done -> rq_err = 1 with rq_done.
REQ-037 Drop and reset: req0 drops in S_WAIT -> rq_done[0] still pulses; reset asserted in S_WAIT -> outputs return to 0 and no rq_done pulse.
REQ-038 Timeout (macro defined, TIMEOUT_CYCLES = 16): no m_done -> rq_done and rq_err both high 16 cycles after S_WAIT entry.
